drive_mode_arbiter: RTL

Top-level owner of the car's motion outputs. It sequences power on/off from a long-press button and arbitrates between the manual, semi-auto and auto driving controllers, enabling exactly one of them at a time. Every mode change passes through a mandatory all-stop drain interval. It sits between the three driving controllers and the motor/indicator outputs, and produces their `*_mode_on` style enables.

---
 rtl/drive_pkg.sv | 46 ++++
 rtl/long_press_toggle.sv | 45 ++++
 rtl/drive_mode_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/drive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drive_pkg
// Description : Shared definitions for the drive mode arbiter: mode encoding,
//               arbiter state enum, motion-vector bit order and a helper that
//               removes contradictory motion commands.
// Revision    : 1.0 - initial release
// ============================================================================
package drive_pkg;

  // Mode encoding used by mode_sel, target and active_mode.
  localparam logic [1:0] MODE_NONE   = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b01;
  localparam logic [1:0] MODE_SEMI   = 2'b10;
  localparam logic [1:0] MODE_AUTO   = 2'b11;

  // Motion vector bit order: {backward, forward, left, right}.
  localparam int MV_BACKWARD = 3;
  localparam int MV_FORWARD  = 2;
  localparam int MV_LEFT     = 1;
  localparam int MV_RIGHT    = 0;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Opposing commands cancel: both axes are cleared independently.
  function automatic logic [3:0] sanitize_move(input logic [3:0] move);
    logic [3:0] w_clean;
    w_clean = move;
    if (move[MV_BACKWARD] && move[MV_FORWARD]) begin
      w_clean[MV_BACKWARD] = 1'b0;
      w_clean[MV_FORWARD]  = 1'b0;
    end
    if (move[MV_LEFT] && move[MV_RIGHT]) begin
      w_clean[MV_LEFT]  = 1'b0;
      w_clean[MV_RIGHT] = 1'b0;
    end
    return w_clean;
  endfunction

endpackage
`default_nettype wire

// File: rtl/long_press_toggle.sv
`default_nettype none
// ============================================================================
// Module      : long_press_toggle
// Description : Counts consecutive cycles of a held button and emits a single
//               one-cycle toggle pulse when the hold reaches HOLD cycles. The
//               counter saturates, so a button that stays pressed never fires
//               again until it is released and pressed anew.
// Ports       : clk      - system clock
//               reset    - asynchronous active-high reset
//               i_button - button level
//               o_toggle - one-cycle pulse, valid in the cycle whose closing
//                          edge brings the count to HOLD
// Revision    : 1.0 - initial release
// ============================================================================
module long_press_toggle #(
  parameter int HOLD = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic i_button,
  output logic o_toggle
);

  localparam int                 c_CNT_W = $clog2(HOLD + 1);
  localparam logic [c_CNT_W-1:0] c_HOLD  = c_CNT_W'(HOLD);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(HOLD - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_button) begin
      r_cnt <= '0;
    end else if (r_cnt != c_HOLD) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Pulse on the edge that moves the count to HOLD; once saturated at HOLD
  // the comparison can no longer match, which is the release-rearm.
  assign o_toggle = i_button && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/drive_mode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : drive_mode_arbiter
// Description : Owns the car's motion outputs. Sequences power from a long
//               button press and enables exactly one of the manual, semi-auto
//               and auto controllers, inserting an all-stop drain interval on
//               every mode change.
// Ports       : clk, reset                 - clock, async active-high reset
//               power_button               - long press toggles power
//               mode_req / mode_sel        - request strobe and requested mode
//               manual/semi/auto_move      - {backward, forward, left, right}
//               move_*/turn_* signals      - arbitrated, sanitised motion
//               power_on                   - high in every state except OFF
//               *_mode_on                  - one-hot-or-zero source enables
//               active_mode                - mode driving the outputs
//               switching                  - high while draining
// Revision    : 1.0 - initial release
// ============================================================================
module drive_mode_arbiter
  import drive_pkg::*;
#(
  parameter int POWER_HOLD   = 100,
  parameter int DRAIN_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_button,
  input  logic       mode_req,
  input  logic [1:0] mode_sel,
  input  logic [3:0] manual_move,
  input  logic [3:0] semi_move,
  input  logic [3:0] auto_move,
  output logic       move_backward_signal,
  output logic       move_forward_signal,
  output logic       turn_left_signal,
  output logic       turn_right_signal,
  output logic       power_on,
  output logic       manual_mode_on,
  output logic       semi_auto_mode_on,
  output logic       auto_mode_on,
  output logic [1:0] active_mode,
  output logic       switching
);

  localparam int                   c_DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_MAX  = c_DRAIN_W'(DRAIN_CYCLES);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_target;
  logic [1:0]           w_target_nxt;
  logic [c_DRAIN_W-1:0] r_drain_cnt;
  logic [c_DRAIN_W-1:0] w_drain_cnt_nxt;
  logic                 w_toggle;
  logic                 w_active_nxt;
  logic [3:0]           w_src;

  logic                 r_power_on;
  logic                 r_switching;
  logic [1:0]           r_active_mode;
  logic                 r_manual_on;
  logic                 r_semi_on;
  logic                 r_auto_on;
  logic [3:0]           r_move;

  long_press_toggle #(
    .HOLD (POWER_HOLD)
  ) u_power_toggle (
    .clk      (clk),
    .reset    (reset),
    .i_button (power_button),
    .o_toggle (w_toggle)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_OFF;
      r_target    <= MODE_NONE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_target    <= w_target_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. In ACTIVE, target holds the mode currently driving.
  // A power toggle wins over everything and swallows a same-cycle request.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_target_nxt    = r_target;
    w_drain_cnt_nxt = r_drain_cnt;

    if (w_toggle) begin
      if (r_state == ST_OFF) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_state_nxt     = ST_OFF;
        w_target_nxt    = MODE_NONE;
        w_drain_cnt_nxt = '0;
      end
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_OFF;
        end
        ST_IDLE: begin
          if (mode_req && (mode_sel != MODE_NONE)) begin
            w_state_nxt     = ST_DRAIN;
            w_target_nxt    = mode_sel;
            w_drain_cnt_nxt = '0;
          end
        end
        ST_ACTIVE: begin
          if (mode_req && (mode_sel != r_target)) begin
            w_state_nxt     = ST_DRAIN;
            w_target_nxt    = mode_sel;
            w_drain_cnt_nxt = '0;
          end
        end
        ST_DRAIN: begin
          if (mode_req) begin
            // Retarget restarts the full drain interval.
            w_target_nxt    = mode_sel;
            w_drain_cnt_nxt = '0;
          end else if (r_drain_cnt == c_DRAIN_LAST) begin
            w_drain_cnt_nxt = '0;
            if (r_target == MODE_NONE) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_ACTIVE;
            end
          end else if (r_drain_cnt != c_DRAIN_MAX) begin
            w_drain_cnt_nxt = r_drain_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output datapath. Outputs are decoded from the next state so that enables
  // and motion switch on the same edge as the state, and motion is cleared
  // the moment a drain or power-off begins.
  // --------------------------------------------------------------------------
  assign w_active_nxt = (w_state_nxt == ST_ACTIVE);

  always_comb begin
    w_src = '0;
    case (w_target_nxt)
      MODE_MANUAL: w_src = manual_move;
      MODE_SEMI:   w_src = semi_move;
      MODE_AUTO:   w_src = auto_move;
      default:     w_src = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_power_on    <= 1'b0;
      r_switching   <= 1'b0;
      r_active_mode <= MODE_NONE;
      r_manual_on   <= 1'b0;
      r_semi_on     <= 1'b0;
      r_auto_on     <= 1'b0;
      r_move        <= '0;
    end else begin
      r_power_on    <= (w_state_nxt != ST_OFF);
      r_switching   <= (w_state_nxt == ST_DRAIN);
      r_active_mode <= w_active_nxt ? w_target_nxt : MODE_NONE;
      r_manual_on   <= w_active_nxt && (w_target_nxt == MODE_MANUAL);
      r_semi_on     <= w_active_nxt && (w_target_nxt == MODE_SEMI);
      r_auto_on     <= w_active_nxt && (w_target_nxt == MODE_AUTO);
      r_move        <= w_active_nxt ? sanitize_move(w_src) : 4'b0000;
    end
  end

  assign power_on             = r_power_on;
  assign switching            = r_switching;
  assign active_mode          = r_active_mode;
  assign manual_mode_on       = r_manual_on;
  assign semi_auto_mode_on    = r_semi_on;
  assign auto_mode_on         = r_auto_on;
  assign move_backward_signal = r_move[MV_BACKWARD];
  assign move_forward_signal  = r_move[MV_FORWARD];
  assign turn_left_signal     = r_move[MV_LEFT];
  assign turn_right_signal    = r_move[MV_RIGHT];

endmodule
`default_nettype wire
